p_cacheline_adaptor: RTL and testbench
======================================

// Module: p_cacheline_adaptor
// PURPOSE
//  Responder on the cache-side pmem interface: accepts one 256-bit line read or write from a cache
//  (pmem_read/pmem_write/pmem_address, 256-bit data, pmem_resp) and performs it on physical memory
//  as a 4-beat x 64-bit burst. Sits between the cache/arbiter and the burst DRAM model; one request in flight.
// PARAMETERS
//  LINE_W   256  cache line width (bits)
//  BURST_W  64   burst beat width (bits); BEATS = LINE_W/BURST_W = 4
//  ADDR_W   32   address width; line offset bits = $clog2(LINE_W/8) = 5
// PORTS
//  clk          in   1        clock; single clock domain
//  rst          in   1        asynchronous, active-low reset
//  line_read    in   1        cache requests line read; held until line_resp
//  line_write   in   1        cache requests line write; held until line_resp
//  line_addr    in   ADDR_W   request address (offset bits ignored)
//  line_wdata   in   LINE_W   write line; sampled in IDLE when request accepted
//  line_rdata   out  LINE_W   assembled read line; valid while line_resp=1, held until next read completes
//  line_resp    out  1        one-cycle completion pulse
//  burst_addr   out  ADDR_W   line-aligned address {line_addr[31:5],5'b0}, held for whole transaction
//  burst_read   out  1        memory read request
//  burst_write  out  1        memory write request
//  burst_wdata  out  BURST_W  current write beat
//  burst_rdata  in   BURST_W  read beat data, valid when burst_resp=1
//  burst_resp   in   1        memory beat strobe (one per beat)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, beat count=0, line buffer=0; all outputs 0.
//  - FSM: IDLE, READ, WRITE, DONE.
//    IDLE: line_read -> capture aligned addr, go READ. line_write (no read) -> capture addr+line_wdata, go WRITE.
//      Both asserted: read wins, write ignored (illegal request; bench flags it).
//    READ: burst_read=1. Each cycle burst_resp=1: buf[cnt*64 +: 64] <= burst_rdata, cnt++.
//      burst_resp on cnt==3 -> DONE. Cycles with burst_resp=0 (before or between beats) just wait.
//    WRITE: burst_write=1, burst_wdata=buf[cnt*64 +: 64]. Each burst_resp=1 advances cnt; burst_resp on cnt==3 -> DONE.
//    DONE: line_resp=1 for exactly one cycle, burst_read/write=0, cnt=0; next state IDLE unconditionally.
//  - Beat order: beat 0 = line bits [63:0], ascending. cnt is 2 bits, wraps 3->0 on entering DONE.
//  - Latency: line_resp asserts the cycle after the 4th burst_resp; minimum read/write = 6 cycles from request.
//  - Requester deasserts its request on the edge where it samples line_resp=1; a request seen in the DONE
//    cycle is not accepted (no back-to-back acceptance without an IDLE cycle).
//  - line_rdata is driven from the line buffer; it is not updated by writes' data path until a new read
//    overwrites it (write reuses the buffer, so line_rdata is undefined-by-contract after a write).
//  - burst_addr, burst_read, burst_write registered from state; no combinational path from burst_resp to outputs
//    other than next-state.
//  - Reset asserted mid-burst: immediate return to IDLE, burst_read/write drop in the same cycle, partial line discarded.
// STRUCTURE
//  - Shared package (cache_mux_types): typedef enum logic [1:0] {ADP_IDLE, ADP_READ, ADP_WRITE, ADP_DONE} adaptor_state_t;
//    localparams for line/beat widths and offset size.
//  - Single module: FSM + 2-bit beat counter + LINE_W buffer register + address register; no sub-module.
// TESTING
//  1. Read addr 0x0000_1234: mem returns 0x11..11,0x22..22,0x33..33,0x44..44 back-to-back -> burst_addr=0x0000_1220,
//     line_rdata={0x44..44,0x33..33,0x22..22,0x11..11}, line_resp one cycle after 4th beat.
//  2. Write line 0x0123..CDEF (4 distinct beats) to 0x8000_0040 -> burst_wdata sequence beat0..3 = line[63:0]..[255:192],
//     write_o held until 4th resp, line_resp single pulse.
//  3. Read with stalls: burst_resp pattern 0,1,0,0,1,1,0,1 -> same assembled line as scenario 1, no beat dropped/duplicated.
//  4. line_read=line_write=1 at 0x100 -> only burst_read asserted, burst_write never 1.
//  5. rst=0 after 2 read beats -> outputs 0 asynchronously; subsequent read of new line yields only new data.
//  6. Back-to-back: read then immediate write held through DONE -> write accepted only after one IDLE cycle; both complete.

Source files
------------

// File: rtl/cache_mux_types.sv
// Shared types and sizing constants for the cache-side memory path.
package cache_mux_types;

   localparam int unsigned ADP_LINE_W   = 256;
   localparam int unsigned ADP_BURST_W  = 64;
   localparam int unsigned ADP_ADDR_W   = 32;
   localparam int unsigned ADP_OFFSET_W = $clog2(ADP_LINE_W / 8);

   typedef enum logic [1:0] {
      ADP_IDLE,
      ADP_READ,
      ADP_WRITE,
      ADP_DONE
   } adaptor_state_t;

endpackage

// File: rtl/p_cacheline_adaptor.sv
// Converts one cache-line read/write into a 4-beat burst on physical memory.
// One request in flight; line_resp pulses for one cycle after the last beat.
module p_cacheline_adaptor
   import cache_mux_types::*;
#(
   parameter int unsigned LINE_W   = ADP_LINE_W,
   parameter int unsigned BURST_W  = ADP_BURST_W,
   parameter int unsigned ADDR_W   = ADP_ADDR_W,
   parameter int unsigned OFFSET_W = ADP_OFFSET_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               line_read,
   input  logic               line_write,
   input  logic [ADDR_W-1:0]  line_addr,
   input  logic [LINE_W-1:0]  line_wdata,
   output logic [LINE_W-1:0]  line_rdata,
   output logic               line_resp,
   output logic [ADDR_W-1:0]  burst_addr,
   output logic               burst_read,
   output logic               burst_write,
   output logic [BURST_W-1:0] burst_wdata,
   input  logic [BURST_W-1:0] burst_rdata,
   input  logic               burst_resp
);

   localparam int unsigned BEATS = LINE_W / BURST_W;
   localparam int unsigned CNT_W = $clog2(BEATS);

   adaptor_state_t state, state_nxt;
   logic [CNT_W-1:0]                 cnt;
   logic [BEATS-1:0][BURST_W-1:0]    line_buf;
   logic [ADDR_W-1:0]                addr_q;
   logic                             last_beat;
   logic                             unused_offset;

   assign unused_offset = ^line_addr[OFFSET_W-1:0];
   assign last_beat     = burst_resp && (cnt == CNT_W'(BEATS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ADP_IDLE;
      else      state <= state_nxt;
   end

   // Read wins when both requests are presented; DONE always passes through IDLE.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ADP_IDLE: begin
            if (line_read)       state_nxt = ADP_READ;
            else if (line_write) state_nxt = ADP_WRITE;
         end
         ADP_READ:  if (last_beat) state_nxt = ADP_DONE;
         ADP_WRITE: if (last_beat) state_nxt = ADP_DONE;
         ADP_DONE:  state_nxt = ADP_IDLE;
         default:   state_nxt = ADP_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         line_buf <= '0;
         addr_q   <= '0;
      end else begin
         unique case (state)
            ADP_IDLE: begin
               if (line_read || line_write)
                  addr_q <= {line_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
               if (!line_read && line_write)
                  line_buf <= line_wdata;
            end
            ADP_READ: begin
               if (burst_resp) begin
                  line_buf[cnt] <= burst_rdata;
                  cnt           <= cnt + CNT_W'(1);
               end
            end
            ADP_WRITE: begin
               if (burst_resp) cnt <= cnt + CNT_W'(1);
            end
            ADP_DONE: cnt <= '0;
            default:  cnt <= '0;
         endcase
      end
   end

   assign burst_addr  = addr_q;
   assign burst_read  = (state == ADP_READ);
   assign burst_write = (state == ADP_WRITE);
   assign line_resp   = (state == ADP_DONE);
   assign burst_wdata = burst_write ? line_buf[cnt] : '0;
   assign line_rdata  = line_buf;

endmodule

// File: tb/tb_p_cacheline_adaptor.sv
// Scoreboard bench for p_cacheline_adaptor: driver pushes expected transactions,
// a memory model answers bursts, a monitor pops and compares on each output event.
module tb_p_cacheline_adaptor;

   logic         clk = 1'b0;
   logic         rst;
   logic         line_read, line_write;
   logic [31:0]  line_addr;
   logic [255:0] line_wdata, line_rdata;
   logic         line_resp;
   logic [31:0]  burst_addr;
   logic         burst_read, burst_write;
   logic [63:0]  burst_wdata, burst_rdata;
   logic         burst_resp;

   typedef struct {
      bit           rd;
      logic [31:0]  addr;
      logic [255:0] line;
   } txn_t;

   txn_t         exp_q[$];
   logic [255:0] mem_rd_q[$];
   bit           pat_q[$];

   int checks = 0;
   int errors = 0;
   int mon_beat = 0;
   int mbeat = 0;
   bit pend_done = 0;
   bit prev_lr = 0;
   txn_t cur;
   logic [255:0] mem_line;

   localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] LINE_W = {64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978,
                                      64'h8899_AABB_CCDD_EEFF, 64'h0123_4567_89AB_CDEF};

   p_cacheline_adaptor dut (
      .clk         (clk),
      .rst         (rst),
      .line_read   (line_read),
      .line_write  (line_write),
      .line_addr   (line_addr),
      .line_wdata  (line_wdata),
      .line_rdata  (line_rdata),
      .line_resp   (line_resp),
      .burst_addr  (burst_addr),
      .burst_read  (burst_read),
      .burst_write (burst_write),
      .burst_wdata (burst_wdata),
      .burst_rdata (burst_rdata),
      .burst_resp  (burst_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Memory model: drives beat strobes/data shortly after each rising edge.
   always @(posedge clk) begin
      bit r;
      #2;
      if (rst !== 1'b1) begin
         burst_resp  = 1'b0;
         burst_rdata = '0;
         mbeat       = 0;
      end else if (burst_read || burst_write) begin
         if (pat_q.size() > 0) r = pat_q.pop_front();
         else                  r = ($urandom_range(0, 2) != 0);
         burst_resp  = r;
         burst_rdata = {$urandom, $urandom};
         if (r && burst_read && mem_rd_q.size() > 0) begin
            mem_line    = mem_rd_q[0];
            burst_rdata = mem_line[mbeat*64 +: 64];
         end
         if (r) begin
            mbeat++;
            if (mbeat == 4) begin
               mbeat = 0;
               if (burst_read && mem_rd_q.size() > 0) void'(mem_rd_q.pop_front());
            end
         end
      end else begin
         burst_resp  = 1'b0;
         burst_rdata = {$urandom, $urandom};
      end
   end

   // Monitor: compares DUT outputs against the head of the expected queue.
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         mon_beat  = 0;
         pend_done = 0;
         prev_lr   = 0;
      end else begin
         chk("line_resp", 256'(line_resp), 256'(pend_done));
         pend_done = 0;
         if (prev_lr) chk("idle_after_done", 256'({burst_read, burst_write}), 256'(0));
         if (line_resp) begin
            if (exp_q.size() == 0) chk("resp_unexpected", 256'(1), 256'(0));
            else begin
               cur = exp_q.pop_front();
               if (cur.rd) chk("line_rdata", line_rdata, cur.line);
            end
            mon_beat = 0;
         end else if (burst_read || burst_write) begin
            if (exp_q.size() == 0) chk("burst_unexpected", 256'(1), 256'(0));
            else begin
               cur = exp_q[0];
               chk("burst_kind", 256'({burst_read, burst_write}), cur.rd ? 256'(2) : 256'(1));
               if (burst_resp) begin
                  chk("burst_addr", 256'(burst_addr), 256'(cur.addr));
                  if (!cur.rd && mon_beat < 4)
                     chk("burst_wdata", 256'(burst_wdata), 256'(cur.line[mon_beat*64 +: 64]));
                  mon_beat++;
                  if (mon_beat == 4) pend_done = 1;
               end
            end
         end
         prev_lr = line_resp;
      end
   end

   task automatic issue(input bit rd, input bit wr, input logic [31:0] addr, input logic [255:0] line);
      txn_t t;
      t.rd   = rd;
      t.addr = addr & 32'hFFFF_FFE0;
      t.line = line;
      if (rd && wr) $display("note: illegal read+write request at %h, read expected to win", addr);
      if (rd) mem_rd_q.push_back(line);
      exp_q.push_back(t);
      line_addr  = addr;
      line_wdata = rd ? {8{$urandom}} : line;
      line_read  = rd;
      line_write = wr;
   endtask

   task automatic wait_resp();
      int n;
      for (n = 0; n < 300; n++) begin
         @(negedge clk);
         if (line_resp === 1'b1) break;
      end
      if (n == 300) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout actual=no line_resp required=line_resp within 300 cycles");
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   endtask

   task automatic xact(input bit rd, input bit wr, input logic [31:0] addr, input logic [255:0] line);
      issue(rd, wr, addr, line);
      wait_resp();
      @(posedge clk);
      #1;
      line_read  = 1'b0;
      line_write = 1'b0;
   endtask

   task automatic push_pat(input logic [7:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) pat_q.push_back(bits[i]);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_burst_read"},  256'(burst_read),  256'(0));
      chk({tag, "_burst_write"}, 256'(burst_write), 256'(0));
      chk({tag, "_line_resp"},   256'(line_resp),   256'(0));
      chk({tag, "_burst_addr"},  256'(burst_addr),  256'(0));
      chk({tag, "_burst_wdata"}, 256'(burst_wdata), 256'(0));
      chk({tag, "_line_rdata"},  line_rdata,        256'(0));
   endtask

   initial begin
      int op;
      rst         = 1'b0;
      line_read   = 1'b0;
      line_write  = 1'b0;
      line_addr   = '0;
      line_wdata  = '0;
      burst_resp  = 1'b0;
      burst_rdata = '0;
      #12;
      chk_outputs_zero("reset");
      @(negedge clk) rst = 1'b1;
      @(posedge clk) #1;

      // back-to-back read
      push_pat(8'b0000_1111, 4);
      xact(1'b1, 1'b0, 32'h0000_1234, LINE_A);

      // back-to-back write with distinct beats
      push_pat(8'b0000_1111, 4);
      xact(1'b0, 1'b1, 32'h8000_0040, LINE_W);

      // read with stalls before and between beats
      push_pat(8'b0100_1101, 8);
      xact(1'b1, 1'b0, 32'h0000_1234, LINE_A);

      // simultaneous read and write: read must win
      xact(1'b1, 1'b1, 32'h0000_0100, {8{$urandom}});

      // reset after two read beats
      issue(1'b1, 1'b0, 32'h0000_2000, {8{$urandom}});
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         #1;
         if (mon_beat >= 2) break;
      end
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk_outputs_zero("midburst_rst");
      line_read = 1'b0;
      exp_q.delete();
      mem_rd_q.delete();
      pat_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk) #1;
      xact(1'b1, 1'b0, 32'h0000_2000, {8{$urandom}});

      // read, then a write raised during the DONE cycle and held
      issue(1'b1, 1'b0, 32'h0000_3000, {8{$urandom}});
      wait_resp();
      line_read = 1'b0;
      issue(1'b0, 1'b1, 32'h0000_3020, {8{$urandom}});
      wait_resp();
      @(posedge clk);
      #1;
      line_write = 1'b0;

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 9);
         if (op == 0)     xact(1'b1, 1'b1, $urandom, {8{$urandom}});
         else if (op < 6) xact(1'b1, 1'b0, $urandom, {8{$urandom}});
         else             xact(1'b0, 1'b1, $urandom, {8{$urandom}});
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end

      repeat (4) @(posedge clk);
      chk("queue_drain", 256'(exp_q.size()), 256'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
